// File: rtl/fib_num_gen.sv
// Iterative seed-scaled Fibonacci generator: f(1)=f(2)=a, f(n)=f(n-1)+f(n-2).
// One addition per clock; sticky error/overflow states cleared only by clear or reset.
module fib_num_gen #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ORDER_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_load,
  input  logic                   i_clear,
  input  logic [ORDER_WIDTH-1:0] i_order,
  input  logic [DATA_WIDTH-1:0]  i_data_in,
  output logic                   o_done,
  output logic                   o_error,
  output logic                   o_overflow,
  output logic [DATA_WIDTH-1:0]  o_data_out
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StComp,
    StDone,
    StError,
    StOvf
  } state_e;

  state_e                 r_state, w_state_next;
  logic [DATA_WIDTH-1:0]  r_prev, w_prev_next;
  logic [DATA_WIDTH-1:0]  r_curr, w_curr_next;
  logic [ORDER_WIDTH-1:0] r_count, w_count_next;
  logic [ORDER_WIDTH-1:0] r_ord, w_ord_next;
  logic [DATA_WIDTH-1:0]  r_data_out, w_data_out_next;
  logic                   r_done, r_error, r_overflow;
  logic [DATA_WIDTH:0]    w_sum;

  // One extra bit so the carry out of DATA_WIDTH is visible.
  assign w_sum = {1'b0, r_prev} + {1'b0, r_curr};

  always_comb begin
    w_state_next    = r_state;
    w_prev_next     = r_prev;
    w_curr_next     = r_curr;
    w_count_next    = r_count;
    w_ord_next      = r_ord;
    w_data_out_next = r_data_out;

    unique case (r_state)
      StIdle: begin
        // Operands arrive one cycle after load rises, so nothing is captured here.
        if (i_load) begin
          w_state_next = StArm;
        end
      end
      StArm: begin
        w_ord_next = i_order;
        if ((i_order == '0) || (i_data_in == '0)) begin
          w_state_next    = StError;
          w_data_out_next = '0;
        end else begin
          w_state_next = StComp;
          w_prev_next  = '0;
          w_curr_next  = i_data_in;
          w_count_next = ORDER_WIDTH'(1);
        end
      end
      StComp: begin
        if (r_count == r_ord) begin
          w_state_next    = StDone;
          w_data_out_next = r_curr;
        end else if (w_sum[DATA_WIDTH]) begin
          w_state_next    = StOvf;
          w_data_out_next = w_sum[DATA_WIDTH-1:0];
        end else begin
          w_prev_next  = r_curr;
          w_curr_next  = w_sum[DATA_WIDTH-1:0];
          w_count_next = r_count + ORDER_WIDTH'(1);
        end
      end
      StDone: begin
        if (!i_load) begin
          w_state_next = StIdle;
        end
      end
      StError, StOvf: begin
        w_state_next = r_state;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Clear aborts any state, including an in-flight computation.
    if (i_clear) begin
      w_state_next    = StIdle;
      w_prev_next     = '0;
      w_curr_next     = '0;
      w_count_next    = '0;
      w_data_out_next = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_prev     <= '0;
      r_curr     <= '0;
      r_count    <= '0;
      r_ord      <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_prev     <= w_prev_next;
      r_curr     <= w_curr_next;
      r_count    <= w_count_next;
      r_ord      <= w_ord_next;
      r_data_out <= w_data_out_next;
      r_done     <= (w_state_next == StDone);
      r_error    <= (w_state_next == StError);
      r_overflow <= (w_state_next == StOvf);
    end
  end

  assign o_done     = r_done;
  assign o_error    = r_error;
  assign o_overflow = r_overflow;
  assign o_data_out = r_data_out;

endmodule

// File: tb/tb_fib_num_gen.sv
// Directed bench for fib_num_gen: latency, seed sweep, error/overflow stickiness,
// clear and reset recovery.
module tb_fib_num_gen;

  logic        clk = 1'b0;
  logic        i_reset, i_load, i_clear;
  logic [15:0] i_order;
  logic [63:0] i_data_in;
  logic        o_done, o_error, o_overflow;
  logic [63:0] o_data_out;

  int n_vec  = 0;
  int n_miss = 0;

  fib_num_gen #(
    .DATA_WIDTH (64),
    .ORDER_WIDTH(16)
  ) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_load    (i_load),
    .i_clear   (i_clear),
    .i_order   (i_order),
    .i_data_in (i_data_in),
    .o_done    (o_done),
    .o_error   (o_error),
    .o_overflow(o_overflow),
    .o_data_out(o_data_out)
  );

  always #5 clk = ~clk;

  // Reference: a*F(n) with wide arithmetic, reporting the first carry out of 64 bits.
  task automatic fib_model(input logic [63:0] a, input int n, output logic [63:0] val,
                           output bit ovf);
    logic [64:0] p, c, s;
    p = '0; c = {1'b0, a}; ovf = 1'b0; val = a;
    for (int k = 1; k < n; k++) begin
      s = p + c;
      if (s[64]) begin
        val = s[63:0]; ovf = 1'b1;
        return;
      end
      p = c; c = s; val = c[63:0];
    end
  endtask

  // Raise load with junk operands, present real ones after the first load edge,
  // then count edges until any status output rises (bounded).
  task automatic do_req(input logic [15:0] ord, input logic [63:0] a, input int bound,
                        output int lat, output logic d, output logic e, output logic o,
                        output logic [63:0] q);
    i_load = 1'b1; i_order = 16'hffff; i_data_in = 64'hdead_beef_0bad_f00d;
    @(posedge clk); #1;
    i_order = ord; i_data_in = a; lat = 0;
    while (lat < bound) begin
      @(posedge clk); #1;
      lat++;
      if (o_done || o_error || o_overflow) break;
    end
    d = o_done; e = o_error; o = o_overflow; q = o_data_out;
  endtask

  task automatic end_req();
    i_load = 1'b0; i_order = '0; i_data_in = '0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    i_load = 1'b0; i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_load = 1'b0; i_clear = 1'b0; i_order = '0; i_data_in = '0;
    #500;
    @(posedge clk); #1;
    n_vec++;
    if ({o_done, o_error, o_overflow} !== 3'b000 || o_data_out !== 64'd0) begin
      n_miss++;
      $display("FAIL reset: got d/e/o=%b%b%b q=%0d want 000 q=0",
               o_done, o_error, o_overflow, o_data_out);
    end
    i_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic d, e, o; logic [63:0] q;
    do_req(16'd10, 64'd1, 40, lat, d, e, o, q);
    n_vec++;
    if (lat !== 11 || d !== 1'b1) begin
      n_miss++; $display("FAIL basic_latency: got lat=%0d done=%b want 11 1", lat, d);
    end
    n_vec++;
    if (q !== 64'd55 || e !== 1'b0 || o !== 1'b0) begin
      n_miss++; $display("FAIL basic_value: got q=%0d e=%b o=%b want 55 0 0", q, e, o);
    end
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (o_done !== 1'b1 || o_data_out !== 64'd55) begin
      n_miss++; $display("FAIL basic_hold: got done=%b q=%0d want 1 55", o_done, o_data_out);
    end
    end_req();
    n_vec++;
    if (o_done !== 1'b0) begin
      n_miss++; $display("FAIL basic_release: got done=%b want 0", o_done);
    end
  endtask

  task automatic test_load_drop();
    int lat;
    i_load = 1'b1; i_order = 16'hffff; i_data_in = '1;
    @(posedge clk); #1;
    i_order = 16'd5; i_data_in = 64'd2;
    @(posedge clk); #1;
    i_load = 1'b0;
    lat = 1;
    while (lat < 20 && !o_done) begin
      @(posedge clk); #1; lat++;
    end
    n_vec++;
    if (lat !== 6 || o_done !== 1'b1 || o_data_out !== 64'd10) begin
      n_miss++;
      $display("FAIL load_drop: got lat=%0d done=%b q=%0d want 6 1 10", lat, o_done, o_data_out);
    end
    @(posedge clk); #1;
    n_vec++;
    if (o_done !== 1'b0) begin
      n_miss++; $display("FAIL load_drop_pulse: got done=%b want 0", o_done);
    end
  endtask

  task automatic test_seed_sweep();
    int lat; logic d, e, o; logic [63:0] q, exp_q; bit exp_o;
    do_req(16'd15, 64'd3, 40, lat, d, e, o, q);
    n_vec++;
    if (q !== 64'd1830 || d !== 1'b1) begin
      n_miss++; $display("FAIL sweep_15x3: got q=%0d done=%b want 1830 1", q, d);
    end
    end_req();
    do_req(16'd80, 64'd1, 100, lat, d, e, o, q);
    n_vec++;
    if (q !== 64'd23416728348467685 || d !== 1'b1) begin
      n_miss++; $display("FAIL sweep_80x1: got q=%0d done=%b want 23416728348467685 1", q, d);
    end
    end_req();
    for (int n = 1; n <= 80; n++) begin
      fib_model(64'(n), n, exp_q, exp_o);
      do_req(16'(n), 64'(n), 100, lat, d, e, o, q);
      n_vec++;
      if (q !== exp_q || d !== 1'b1 || lat !== n + 1 || e !== 1'b0 || o !== 1'b0) begin
        n_miss++;
        $display("FAIL sweep_n%0d: got q=%0d lat=%0d d/e/o=%b%b%b want q=%0d lat=%0d 100",
                 n, q, lat, d, e, o, exp_q, n + 1);
      end
      end_req();
    end
  endtask

  task automatic test_error_order0();
    int lat; logic d, e, o; logic [63:0] q; int bad;
    do_req(16'd0, 64'd1, 20, lat, d, e, o, q);
    n_vec++;
    if (e !== 1'b1 || lat !== 1 || d !== 1'b0 || q !== 64'd0) begin
      n_miss++;
      $display("FAIL err_order0: got e=%b lat=%0d d=%b q=%0d want 1 1 0 0", e, lat, d, q);
    end
    bad = 0;
    repeat (22) begin
      @(posedge clk); #1;
      if (o_error !== 1'b1 || o_done !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_miss++; $display("FAIL err_sticky: got %0d bad cycles want 0", bad);
    end
    pulse_clear();
    n_vec++;
    if (o_error !== 1'b0 || o_data_out !== 64'd0) begin
      n_miss++; $display("FAIL err_clear: got e=%b q=%0d want 0 0", o_error, o_data_out);
    end
    do_req(16'd10, 64'd1, 40, lat, d, e, o, q);
    n_vec++;
    if (q !== 64'd55 || d !== 1'b1) begin
      n_miss++; $display("FAIL err_recover: got q=%0d done=%b want 55 1", q, d);
    end
    end_req();
  endtask

  task automatic test_error_seed0();
    int lat; logic d, e, o; logic [63:0] q;
    do_req(16'd5, 64'd0, 20, lat, d, e, o, q);
    n_vec++;
    if (e !== 1'b1 || d !== 1'b0 || o !== 1'b0) begin
      n_miss++; $display("FAIL err_seed0: got e=%b d=%b o=%b want 1 0 0", e, d, o);
    end
    pulse_clear();
    do_req(16'd10, 64'd2, 40, lat, d, e, o, q);
    n_vec++;
    if (q !== 64'd110 || d !== 1'b1 || e !== 1'b0) begin
      n_miss++; $display("FAIL seed0_recover: got q=%0d d=%b e=%b want 110 1 0", q, d, e);
    end
    end_req();
  endtask

  task automatic test_overflow();
    int lat; logic d, e, o; logic [63:0] q, exp_q; bit exp_o; int bad;
    fib_model(64'd1, 1500, exp_q, exp_o);
    do_req(16'd1500, 64'd1, 150, lat, d, e, o, q);
    n_vec++;
    if (o !== 1'b1 || d !== 1'b0 || lat !== 94) begin
      n_miss++; $display("FAIL ovf_flag: got o=%b d=%b lat=%0d want 1 0 94", o, d, lat);
    end
    n_vec++;
    // Low 64 bits of F(94) = 19740274219868223167.
    if (q !== 64'd1293530146158671551 || q !== exp_q || exp_o !== 1'b1) begin
      n_miss++; $display("FAIL ovf_value: got q=%0d want 1293530146158671551", q);
    end
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_overflow !== 1'b1 || o_done !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_miss++; $display("FAIL ovf_sticky: got %0d bad cycles want 0", bad);
    end
    pulse_clear();
    n_vec++;
    if (o_overflow !== 1'b0 || o_data_out !== 64'd0) begin
      n_miss++; $display("FAIL ovf_clear: got o=%b q=%0d want 0 0", o_overflow, o_data_out);
    end
    do_req(16'd15, 64'd1, 40, lat, d, e, o, q);
    n_vec++;
    if (q !== 64'd610 || d !== 1'b1) begin
      n_miss++; $display("FAIL ovf_recover: got q=%0d d=%b want 610 1", q, d);
    end
    end_req();
  endtask

  task automatic test_order93();
    int lat; logic d, e, o; logic [63:0] q;
    do_req(16'd93, 64'd1, 120, lat, d, e, o, q);
    n_vec++;
    if (q !== 64'd12200160415121876738 || d !== 1'b1 || o !== 1'b0 || lat !== 94) begin
      n_miss++;
      $display("FAIL order93: got q=%0d d=%b o=%b lat=%0d want 12200160415121876738 1 0 94",
               q, d, o, lat);
    end
    end_req();
  endtask

  task automatic test_clear_mid_comp();
    int lat; logic d, e, o; logic [63:0] q; int seen;
    do_req(16'd50, 64'd1, 10, lat, d, e, o, q);
    pulse_clear();
    n_vec++;
    if ({o_done, o_error, o_overflow} !== 3'b000 || o_data_out !== 64'd0) begin
      n_miss++; $display("FAIL clear_mid: got d/e/o=%b%b%b q=%0d want 000 0",
                         o_done, o_error, o_overflow, o_data_out);
    end
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (o_done) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_miss++; $display("FAIL clear_no_done: got %0d done cycles want 0", seen);
    end
    do_req(16'd4, 64'd7, 20, lat, d, e, o, q);
    n_vec++;
    if (q !== 64'd21 || d !== 1'b1) begin
      n_miss++; $display("FAIL clear_recover: got q=%0d d=%b want 21 1", q, d);
    end
  endtask

  // Entered with the previous request still held in DONE.
  task automatic test_reset_in_done();
    n_vec++;
    if (o_done !== 1'b1) begin
      n_miss++; $display("FAIL rst_done_pre: got done=%b want 1", o_done);
    end
    i_reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({o_done, o_error, o_overflow} !== 3'b000 || o_data_out !== 64'd0) begin
      n_miss++; $display("FAIL rst_in_done: got d/e/o=%b%b%b q=%0d want 000 0",
                         o_done, o_error, o_overflow, o_data_out);
    end
    i_reset = 1'b0; i_load = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_drop();
    test_seed_sweep();
    test_error_order0();
    test_error_seed0();
    test_overflow();
    test_order93();
    test_clear_mid_comp();
    test_reset_in_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
